// File: rtl/trig_wheel_pkg.sv
// Shared constants and configuration bundle for the trigger-wheel generator.
// Default wheel geometry, reset period and the latched configuration record.
package trig_wheel_pkg;

    localparam int TEETH      = 60;
    localparam int MISSING    = 2;
    localparam int DEF_PERIOD = 256;
    localparam int CFG_PW     = 16;
    localparam int CFG_TW     = 8;

    typedef struct packed {
        logic [CFG_PW-1:0] period;
        logic [CFG_PW-1:0] min;
        logic [CFG_PW-1:0] step;
        logic [CFG_TW-1:0] cam_start;
        logic [CFG_TW-1:0] cam_stop;
    } trig_cfg_t;

    // Periods below two ticks cannot form a low and a high half.
    function automatic logic [CFG_PW-1:0] clamp2(input logic [CFG_PW-1:0] v);
        return (v < CFG_PW'(2)) ? CFG_PW'(2) : v;
    endfunction

endpackage

// File: rtl/trig_wheel_gen_tooth_timer.sv
// Tick counter for one tooth: low half, high half, end-of-tooth pulse.
// The tooth length is supplied by the parent and is stable within a tooth.
module tooth_timer
    import trig_wheel_pkg::*;
#(
    parameter int LW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    input  logic [LW-1:0] len,
    output logic          crank,
    output logic          stb,
    output logic          last
);

    localparam logic [LW-1:0] ONE = LW'(1);

    logic [LW-1:0] tcnt;
    logic [LW-1:0] half;
    logic [LW-1:0] tcnt_inc;

    assign half     = len >> 1;
    assign tcnt_inc = tcnt + ONE;
    assign last     = ena && (tcnt >= len - ONE);

    // Advance the tick count; crank reflects the post-edge position in the tooth.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            crank <= 1'b0;
            stb   <= 1'b0;
        end else if (clr) begin
            tcnt  <= '0;
            crank <= 1'b0;
            stb   <= 1'b0;
        end else if (last) begin
            tcnt  <= '0;
            crank <= 1'b0;
            stb   <= 1'b1;
        end else if (ena) begin
            tcnt  <= tcnt_inc;
            crank <= (tcnt_inc >= half);
            stb   <= 1'b0;
        end else begin
            stb   <= 1'b0;
        end
    end

endmodule

// File: rtl/trig_wheel_gen.sv
// N-minus-M crank wheel with phase-qualified cam window and linear speed-up.
// Holds tooth index, engine phase, period acceleration and cam decode.
module trig_wheel_gen #(
    parameter int TEETH      = trig_wheel_pkg::TEETH,
    parameter int MISSING    = trig_wheel_pkg::MISSING,
    parameter int PW         = trig_wheel_pkg::CFG_PW,
    parameter int TW         = trig_wheel_pkg::CFG_TW,
    parameter int DEF_PERIOD = trig_wheel_pkg::DEF_PERIOD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load,
    input  logic [PW-1:0] cfg_period,
    input  logic [PW-1:0] cfg_min,
    input  logic [PW-1:0] cfg_step,
    input  logic [TW-1:0] cfg_cam_start,
    input  logic [TW-1:0] cfg_cam_stop,
    output logic          crank_out,
    output logic          cam_out,
    output logic [TW-1:0] tooth_idx,
    output logic          phase,
    output logic          tooth_stb,
    output logic          rev_stb
);

    import trig_wheel_pkg::*;

    localparam int L  = TEETH - MISSING - 1;
    localparam int LW = PW + $clog2(MISSING + 2);

    trig_cfg_t     cfg_q;
    trig_cfg_t     cfg_nxt;
    trig_cfg_t     cfg_in;
    logic [TW-1:0] idx_q;
    logic [TW-1:0] idx_nxt;
    logic          phase_q;
    logic          phase_nxt;
    logic          wrap;
    logic          cam_nxt;
    logic          clr;
    logic          last;
    logic          is_gap;
    logic [LW-1:0] len;
    logic [PW-1:0] per_acc;

    assign clr    = load & ~ena;
    assign is_gap = (idx_q == TW'(L));
    assign len    = is_gap ? LW'(cfg_q.period) * LW'(MISSING + 1)
                           : LW'(cfg_q.period);

    assign cfg_in = '{
        period:    clamp2(cfg_period),
        min:       clamp2(cfg_min),
        step:      cfg_step,
        cam_start: cfg_cam_start,
        cam_stop:  cfg_cam_stop
    };

    // Decrement saturates at the floor without ever underflowing.
    always_comb begin
        per_acc = cfg_q.min;
        if (cfg_q.step < cfg_q.period) begin
            if ((cfg_q.period - cfg_q.step) > cfg_q.min) begin
                per_acc = cfg_q.period - cfg_q.step;
            end
        end
    end

    // Next index, phase, period and cam level for this edge.
    always_comb begin
        cfg_nxt   = cfg_q;
        idx_nxt   = idx_q;
        phase_nxt = phase_q;
        wrap      = 1'b0;
        unique case (1'b1)
            clr: begin
                cfg_nxt   = cfg_in;
                idx_nxt   = '0;
                phase_nxt = 1'b0;
            end
            last: begin
                cfg_nxt.period = per_acc;
                if (is_gap) begin
                    idx_nxt   = '0;
                    phase_nxt = ~phase_q;
                    wrap      = 1'b1;
                end else begin
                    idx_nxt = idx_q + TW'(1);
                end
            end
            default: ;
        endcase
        cam_nxt = phase_nxt
                & (idx_nxt >= cfg_nxt.cam_start)
                & (idx_nxt <  cfg_nxt.cam_stop);
    end

    // Wheel position, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '{
                period:    PW'(DEF_PERIOD),
                min:       PW'(DEF_PERIOD),
                step:      '0,
                cam_start: '0,
                cam_stop:  '0
            };
            idx_q   <= '0;
            phase_q <= 1'b0;
            rev_stb <= 1'b0;
            cam_out <= 1'b0;
        end else begin
            cfg_q   <= cfg_nxt;
            idx_q   <= idx_nxt;
            phase_q <= phase_nxt;
            rev_stb <= wrap;
            cam_out <= cam_nxt;
        end
    end

    assign tooth_idx = idx_q;
    assign phase     = phase_q;

    tooth_timer #(
        .LW(LW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .clr  (clr),
        .len  (len),
        .crank(crank_out),
        .stb  (tooth_stb),
        .last (last)
    );

endmodule

// File: tb/tb_trig_wheel_gen.sv
// Bench for trig_wheel_gen: vector table, directed corners, random vs. model.
// The model expands each configuration into a per-enabled-cycle timeline.
module tb_trig_wheel_gen;

    import trig_wheel_pkg::*;

    localparam int L = TEETH - MISSING - 1;
    localparam int NTL = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        load;
    logic [15:0] cfg_period;
    logic [15:0] cfg_min;
    logic [15:0] cfg_step;
    logic [7:0]  cfg_cam_start;
    logic [7:0]  cfg_cam_stop;
    logic        crank_out;
    logic        cam_out;
    logic [7:0]  tooth_idx;
    logic        phase;
    logic        tooth_stb;
    logic        rev_stb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int p;
        int m;
        int s;
        int len[5];
        int gap;
    } vec_t;

    vec_t        tbl[6];
    logic [12:0] tl[$];

    trig_wheel_gen dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .load         (load),
        .cfg_period   (cfg_period),
        .cfg_min      (cfg_min),
        .cfg_step     (cfg_step),
        .cfg_cam_start(cfg_cam_start),
        .cfg_cam_stop (cfg_cam_stop),
        .crank_out    (crank_out),
        .cam_out      (cam_out),
        .tooth_idx    (tooth_idx),
        .phase        (phase),
        .tooth_stb    (tooth_stb),
        .rev_stb      (rev_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int p, input int m, input int s,
                           input int cs, input int ce);
        ena           = 1'b0;
        cfg_period    = 16'(p);
        cfg_min       = 16'(m);
        cfg_step      = 16'(s);
        cfg_cam_start = 8'(cs);
        cfg_cam_stop  = 8'(ce);
        load          = 1'b1;
        tick();
        load          = 1'b0;
    endtask

    task automatic wait_stb(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tooth_stb && n < limit);
        if (!tooth_stb) n = -1;
    endtask

    task automatic set_vec(input int i, input int p, input int m, input int s,
                           input int l0, input int l1, input int l2,
                           input int l3, input int l4, input int g);
        tbl[i].p      = p;
        tbl[i].m      = m;
        tbl[i].s      = s;
        tbl[i].len[0] = l0;
        tbl[i].len[1] = l1;
        tbl[i].len[2] = l2;
        tbl[i].len[3] = l3;
        tbl[i].len[4] = l4;
        tbl[i].gap    = g;
    endtask

    function automatic bit cam_of(input int i, input int ph,
                                  input int cs, input int ce);
        return (ph == 1) && (i >= cs) && (i < ce);
    endfunction

    function automatic logic [12:0] pack(input bit c, input bit a, input bit ph,
                                         input bit st, input bit rv, input int ix);
        return {c, a, ph, st, rv, 8'(ix)};
    endfunction

    // Expected output state after each enabled edge, index 0 = just loaded.
    task automatic build_tl(input int p, input int m, input int s,
                            input int cs, input int ce);
        int per;
        int mn;
        int i;
        int ph;
        int len;
        int i2;
        int ph2;
        per = (p < 2) ? 2 : p;
        mn  = (m < 2) ? 2 : m;
        i   = 0;
        ph  = 0;
        tl.delete();
        tl.push_back('0);
        while (tl.size() <= NTL) begin
            len = (i == L) ? per * (MISSING + 1) : per;
            i2  = (i == L) ? 0 : i + 1;
            ph2 = (i == L) ? 1 - ph : ph;
            for (int k = 1; k < len; k++)
                tl.push_back(pack(k >= len / 2, cam_of(i, ph, cs, ce),
                                  ph[0], 1'b0, 1'b0, i));
            tl.push_back(pack(1'b0, cam_of(i2, ph2, cs, ce), ph2[0],
                              1'b1, i == L, i2));
            per = (per - s > mn) ? per - s : mn;
            i   = i2;
            ph  = ph2;
        end
    endtask

    initial begin
        int n;
        int first;
        int cam_cnt;
        int bad;
        int k;
        int cyc;
        int p;
        int m;
        int s;
        int cs;
        int ce;
        logic [12:0] act;
        logic [12:0] exp;

        rst = 1'b1;
        ena = 1'b0;
        load = 1'b0;
        cfg_period = '0;
        cfg_min = '0;
        cfg_step = '0;
        cfg_cam_start = '0;
        cfg_cam_stop = '0;
        tick();
        tick();
        rst = 1'b0;

        act = {crank_out, cam_out, phase, tooth_stb, rev_stb, tooth_idx};
        chk("reset_outputs", act, 0);
        chk("reset_per", dut.cfg_q.period, 256);
        chk("reset_min", dut.cfg_q.min, 256);
        chk("reset_step", dut.cfg_q.step, 0);

        set_vec(0, 10, 2, 0, 10, 10, 10, 10, 10, 30);
        set_vec(1, 20, 8, 3, 20, 17, 14, 11, 8, 24);
        set_vec(2, 5, 2, 9, 5, 2, 2, 2, 2, 6);
        set_vec(3, 0, 0, 0, 2, 2, 2, 2, 2, 6);
        set_vec(4, 7, 3, 1, 7, 6, 5, 4, 3, 9);
        set_vec(5, 4, 9, 0, 4, 9, 9, 9, 9, 27);

        for (int r = 0; r < 6; r++) begin
            do_load(tbl[r].p, tbl[r].m, tbl[r].s, 0, 0);
            ena = 1'b1;
            for (int t = 0; t <= L; t++) begin
                wait_stb(100, n);
                if (t < 5)
                    chk($sformatf("row%0d_len%0d", r, t), n, tbl[r].len[t]);
                if (t == L) begin
                    chk($sformatf("row%0d_gap", r), n, tbl[r].gap);
                    chk($sformatf("row%0d_wrap_idx", r), tooth_idx, 0);
                    chk($sformatf("row%0d_rev_stb", r), rev_stb, 1);
                end
            end
            ena = 1'b0;
        end

        do_load(10, 2, 0, 4, 54);
        ena = 1'b1;
        first = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (crank_out && first < 0) first = c;
            if (c == 10) begin
                chk("first_fall_crank", crank_out, 0);
                chk("first_fall_stb", tooth_stb, 1);
            end
        end
        chk("first_rise_cycle", first, 5);
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? 10 : 0;
            cam_cnt = 0;
            bad = 0;
            do begin
                tick();
                n++;
                if (cam_out) cam_cnt++;
                if (cam_out && !(tooth_idx >= 4 && tooth_idx < 54)) bad++;
            end while (!rev_stb && n < 1000);
            chk($sformatf("rev%0d_period", r), n, 600);
            chk($sformatf("rev%0d_cam_cycles", r), cam_cnt, (r == 1) ? 500 : 0);
            chk($sformatf("rev%0d_cam_outside", r), bad, 0);
        end
        ena = 1'b0;

        do_load(5, 2, 9, 0, 0);
        ena = 1'b1;
        wait_stb(50, n);
        chk("sat_first_len", n, 5);
        chk("sat_crank_t0", crank_out, 0);
        tick();
        chk("sat_crank_t1", crank_out, 1);
        chk("sat_stb_t1", tooth_stb, 0);
        tick();
        chk("sat_stb_t2", tooth_stb, 1);
        chk("sat_crank_t2", crank_out, 0);
        ena = 1'b0;

        do_load(10, 2, 0, 0, 0);
        ena = 1'b1;
        tick();
        tick();
        tick();
        ena = 1'b0;
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (tooth_stb || rev_stb) bad++;
        end
        chk("freeze_strobes", bad, 0);
        ena = 1'b1;
        wait_stb(50, n);
        chk("freeze_resume_len", n, 7);
        tick();
        tick();
        cfg_period = 16'd3;
        cfg_step = 16'd1;
        cfg_cam_stop = 8'd60;
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_stb(50, n);
        chk("load_ignored_rest", n, 7);
        wait_stb(50, n);
        chk("load_ignored_len", n, 10);
        chk("load_ignored_idx", tooth_idx, 3);
        chk("load_ignored_per", dut.cfg_q.period, 10);
        ena = 1'b0;

        do_load(4, 2, 0, 0, 60);
        ena = 1'b1;
        n = 0;
        while (tooth_idx != 8'd30 && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reach_idx", tooth_idx, 30);
        tick();
        tick();
        tick();
        chk("rst_pre_crank", crank_out, 1);
        rst = 1'b1;
        load = 1'b1;
        tick();
        rst = 1'b0;
        load = 1'b0;
        ena = 1'b0;
        act = {crank_out, cam_out, phase, tooth_stb, rev_stb, tooth_idx};
        chk("rst_mid_outputs", act, 0);
        chk("rst_mid_per", dut.cfg_q.period, 256);
        ena = 1'b1;
        wait_stb(400, n);
        chk("rst_default_len", n, 256);
        ena = 1'b0;

        for (int rnd = 0; rnd < 4; rnd++) begin
            p  = $urandom_range(1, 9);
            m  = $urandom_range(1, 6);
            s  = $urandom_range(0, 2);
            cs = $urandom_range(0, 60);
            ce = $urandom_range(0, 60);
            do_load(p, m, s, cs, ce);
            build_tl(p, m, s, cs, ce);
            k = 0;
            cyc = 0;
            while (k < NTL && cyc < 6000) begin
                ena  = ($urandom_range(0, 99) < 85);
                load = ena && ($urandom_range(0, 99) < 4);
                if (load) begin
                    cfg_period    = 16'($urandom_range(0, 40));
                    cfg_min       = 16'($urandom_range(0, 40));
                    cfg_step      = 16'($urandom_range(0, 40));
                    cfg_cam_start = 8'($urandom_range(0, 60));
                    cfg_cam_stop  = 8'($urandom_range(0, 60));
                end
                tick();
                load = 1'b0;
                cyc++;
                if (ena) k++;
                exp = tl[k];
                if (!ena) exp[9:8] = 2'b00;
                act = {crank_out, cam_out, phase, tooth_stb, rev_stb, tooth_idx};
                checks++;
                if (act != exp) begin
                    errors++;
                    $display("FAIL rand%0d_cyc%0d: got %h expected %h",
                             rnd, cyc, act, exp);
                end
            end
            chk($sformatf("rand%0d_progress", rnd), k, NTL);
            ena = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_wheel_gen.md
# trig_wheel_gen

Synthesizable, parametrised crank/cam trigger-wheel generator: produces a VR-style crank tooth signal for an N-minus-M wheel and a phase-qualified cam window, with programmable tooth period and per-tooth linear acceleration down to a floor. It is the hardware stimulus source for `hwag` bring-up: its `crank_out` drives `hwag.cap_in` on the board and in benches. It replaces the behavioural 60-2 wheel generator, adding runtime configuration, arbitrary tooth and gap counts, and saturating acceleration.

## Interface
- `TEETH`, 60, physical tooth positions per revolution, including missing ones.
- `MISSING`, 2, missing teeth forming the gap; requires `1 <= MISSING <= TEETH-2`.
- `PW`, 16, tooth-period width in clk ticks.
- `TW`, 8, tooth-index width; requires `2**TW >= TEETH`.
- `DEF_PERIOD`, 256, reset value of the period register.
- `clk`, in, 1, single clock. Reset is synchronous, active-high.
- `rst`, in, 1, synchronous, active-high reset.
- `ena`, in, 1, run enable. Low freezes all state; outputs hold.
- `load`, in, 1, one-cycle pulse that latches all `cfg_*` inputs. Honoured only when `ena`=0.
- `cfg_period`, in, PW, initial tooth period in ticks. Values below 2 are stored as 2.
- `cfg_min`, in, PW, acceleration floor. Values below 2 are stored as 2.
- `cfg_step`, in, PW, period decrement applied per tooth; 0 gives constant speed.
- `cfg_cam_start`, in, TW, first tooth index of the cam window.
- `cfg_cam_stop`, in, TW, tooth index at which the cam window ends (exclusive).
- `crank_out`, out, 1, tooth signal.
- `cam_out`, out, 1, cam signal.
- `tooth_idx`, out, TW, current tooth index, 0..`TEETH-MISSING-1`.
- `phase`, out, 1, engine-cycle half; toggles on every revolution wrap.
- `tooth_stb`, out, 1, one-cycle pulse at each tooth end.
- `rev_stb`, out, 1, one-cycle pulse when `tooth_idx` wraps to 0.

## Operation
- Indices run 0..L, where L = `TEETH-MISSING-1`. Index L is the gap tooth. Its length is `per*(MISSING+1)`; every other tooth is `per` long.
- Tick counter `tcnt` counts 0..len-1 within a tooth.
- `crank_out` is 0 while `tcnt < len>>1` and 1 otherwise. The rising edge therefore falls at mid-tooth and the falling edge at the tooth boundary.
- At a tooth end (`tcnt == len-1`, `ena`=1):
  - `tcnt` returns to 0.
  - `tooth_stb` pulses.
  - `per` becomes `max(per - step, min)`, computed without underflow: if `step >= per`, `per` becomes `min`.
  - If `idx == L`: `idx` goes to 0, `phase` toggles, `rev_stb` pulses. Otherwise `idx` increments.
- The new `per` applies from the next tooth. The gap length uses the `per` in force at gap start.
- `cam_out` is registered and equals `phase & (idx >= cam_start) & (idx < cam_stop)`, evaluated on the post-update `idx`/`phase`. If `cam_start >= cam_stop`, `cam_out` stays at 0.
- `load` with `ena`=0:
  - latches the configuration;
  - sets `per` to the clamped `cfg_period`;
  - clears `tcnt`, `idx` and `phase`.
- `load` with `ena`=1 is ignored.

## Timing
- Reset values:
  - `crank_out`, `cam_out`, `tooth_idx`, `phase`, `tooth_stb`, `rev_stb`, `tcnt`: 0.
  - `per`: `DEF_PERIOD`.
  - `min`: `DEF_PERIOD`.
  - `step`: 0.
  - `cam_start`: 0; `cam_stop`: 0.
- All outputs are registered, with zero combinational paths from inputs.
- `tooth_stb`, `rev_stb`, the new `tooth_idx`/`phase`, and the updated `cam_out` all become valid on the same clk edge that ends the tooth.
- First tooth after reset or `load`: `crank_out` rises `len>>1` cycles after `ena` goes high, and `tooth_stb` fires `len` cycles after it.
- `ena` deasserted mid-tooth freezes `tcnt`. Resuming continues the tooth; no cycles are lost and none are repeated. Strobes are 0 while `ena`=0.
- `rst` has priority over `load` and `ena`. `rst` asserted mid-tooth returns every register to its reset value on the next edge.
- Width rule: gap length is held in `PW+$clog2(MISSING+2)` bits, and `tcnt` has the same width. No wrap is possible for any legal `per`.

## Structure
- Package `trig_wheel_pkg` holds:
  - the default constants (`TEETH`, `MISSING`, `DEF_PERIOD`);
  - a `trig_cfg_t` struct with period, min, step, cam_start and cam_stop.
- One sub-module: `tooth_timer`. It contains the tick counter, the half-length compare and the tooth-end pulse, with `len` as input. The top level holds the index, phase, acceleration and cam logic.

## Test plan
- Reset, then `load` with period=10, step=0, cam 4..54, then `ena`=1:
  - `crank_out` rises at cycle 5 and falls at cycle 10;
  - 57 short teeth, then a 30-cycle gap;
  - `rev_stb` every 600 cycles.
- Cam phase check with the same configuration:
  - `cam_out` is 0 throughout the first revolution;
  - in the second revolution (`phase`=1) it is 1 for exactly idx 4..53;
  - in the third revolution it is 0 again.
- Acceleration with period=20, step=3, min=8:
  - tooth lengths are 20, 17, 14, 11, 8, 8, …;
  - the gap at that point is 24.
- Step saturation with period=5, step=9, min=2:
  - the second tooth is 2 cycles long;
  - `crank_out` is 0 for 1 cycle and 1 for 1 cycle.
- Freeze with period=10: drop `ena` for 7 cycles at `tcnt`=3:
  - `tooth_stb` is delayed by exactly 7 cycles;
  - `load` pulsed while `ena`=1 changes nothing.
- Mid-run `rst` at idx=30: all outputs read 0 and `per` reads 256 on the next cycle.
